// File: rtl/fast_io_pkg.sv
// Shared definitions for the fast converter I/O blocks: ADC word width,
// frame-lock state encoding and the full-scale codes used for overrange.
package fast_io_pkg;

  localparam int ADC_W = 16;

  localparam logic [ADC_W-1:0] FS_POS = 16'h7FFF;
  localparam logic [ADC_W-1:0] FS_NEG = 16'h8000;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  function automatic logic is_full_scale(input logic [ADC_W-1:0] w);
    return (w == FS_POS) || (w == FS_NEG);
  endfunction

endpackage

// File: rtl/adc_frame_lock.sv
// Frame lock for the interleaved ADC stream: checks that the channel marker
// alternates, runs the SEARCH/LOCKED FSM and counts framing violations.
module adc_frame_lock
  import fast_io_pkg::*;
#(
  parameter int LOCK_CNT = 16,
  parameter int ERR_W    = 8
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             word_vld,
  input  logic             sel,
  output logic             viol,
  output logic             lock_evt,
  output logic             locked,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [7:0]       RUN_LAST = 8'(LOCK_CNT - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  lock_state_e state_r;
  logic [7:0]  run_r;
  logic        sel_prev_r;
  logic        have_prev_r;
  logic        good_s;

  // Classify the current word: violation, good alternation, or neither (no history yet)
  always_comb begin
    viol     = 1'b0;
    good_s   = 1'b0;
    lock_evt = 1'b0;
    if (word_vld && have_prev_r) begin
      viol   = (sel == sel_prev_r);
      good_s = (sel != sel_prev_r);
    end else begin
      viol   = 1'b0;
      good_s = 1'b0;
    end
    if ((state_r == SEARCH) && good_s && (run_r == RUN_LAST)) begin
      lock_evt = 1'b1;
    end else begin
      lock_evt = 1'b0;
    end
  end

  // Lock FSM, run counter, marker history and saturating error counter
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_r     <= SEARCH;
      run_r       <= 8'd0;
      locked      <= 1'b0;
      err_cnt     <= {ERR_W{1'b0}};
      sel_prev_r  <= 1'b0;
      have_prev_r <= 1'b0;
    end else begin
      if (word_vld) begin
        sel_prev_r  <= sel;
        have_prev_r <= 1'b1;
      end
      if (viol && (err_cnt != ERR_MAX)) begin
        err_cnt <= err_cnt + ERR_W'(1);
      end
      case (state_r)
        SEARCH: begin
          if (lock_evt) begin
            state_r <= LOCKED;
            locked  <= 1'b1;
            run_r   <= 8'd0;
          end else if (viol) begin
            run_r <= 8'd0;
          end else if (good_s) begin
            run_r <= run_r + 8'd1;
          end
        end
        LOCKED: begin
          if (viol) begin
            state_r <= SEARCH;
            locked  <= 1'b0;
            run_r   <= 8'd0;
          end
        end
        default: begin
          state_r <= SEARCH;
          locked  <= 1'b0;
          run_r   <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: rtl/fast_adc_capture.sv
// Capture side of the interleaved dual-channel ADC bus: IOB registers, format
// conversion, A/B pairing once frame-locked, and sticky overrange flags.
module fast_adc_capture
  import fast_io_pkg::*;
#(
  parameter bit OFFSET_BIN = 1'b0,
  parameter int LOCK_CNT   = 16,
  parameter int ERR_W      = 8
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic [ADC_W-1:0] adc_d,
  input  logic             adc_sel,
  input  logic             ovr_clr,
  output logic [ADC_W-1:0] s_out0,
  output logic [ADC_W-1:0] s_out1,
  output logic             s_valid,
  output logic             locked,
  output logic [ERR_W-1:0] err_cnt,
  output logic             ovr0,
  output logic             ovr1
);

  (* IOB = "TRUE" *) logic [ADC_W-1:0] d1_r;
  (* IOB = "TRUE" *) logic             sel1_r;
  logic             v1_r;
  logic [ADC_W-1:0] hold_a_r;
  logic             a_pend_r;
  logic             viol_s;
  logic             lock_evt_s;
  logic             pair_s;
  logic             set0_s;
  logic             set1_s;

  adc_frame_lock #(
    .LOCK_CNT (LOCK_CNT),
    .ERR_W    (ERR_W)
  ) u_lock (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .word_vld (v1_r),
    .sel      (sel1_r),
    .viol     (viol_s),
    .lock_evt (lock_evt_s),
    .locked   (locked),
    .err_cnt  (err_cnt)
  );

  // Pad-side capture; offset-binary words get their MSB flipped to two's complement
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      d1_r   <= {ADC_W{1'b0}};
      sel1_r <= 1'b0;
      v1_r   <= 1'b0;
    end else begin
      d1_r   <= {adc_d[ADC_W-1] ^ OFFSET_BIN, adc_d[ADC_W-2:0]};
      sel1_r <= adc_sel;
      v1_r   <= 1'b1;
    end
  end

  // Pair decision and full-scale detection for the word in stage 1
  always_comb begin
    pair_s = 1'b0;
    set0_s = 1'b0;
    set1_s = 1'b0;
    if (v1_r) begin
      pair_s = !sel1_r && a_pend_r && locked && !viol_s;
      set0_s = sel1_r && is_full_scale(d1_r);
      set1_s = !sel1_r && is_full_scale(d1_r);
    end else begin
      pair_s = 1'b0;
      set0_s = 1'b0;
      set1_s = 1'b0;
    end
  end

  // Pairing registers and sticky overrange; a new full-scale word beats a clear
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      s_out0   <= {ADC_W{1'b0}};
      s_out1   <= {ADC_W{1'b0}};
      s_valid  <= 1'b0;
      hold_a_r <= {ADC_W{1'b0}};
      a_pend_r <= 1'b0;
      ovr0     <= 1'b0;
      ovr1     <= 1'b0;
    end else begin
      s_valid <= pair_s;
      if (pair_s) begin
        s_out0 <= hold_a_r;
        s_out1 <= d1_r;
      end
      if (v1_r && sel1_r) begin
        hold_a_r <= d1_r;
      end
      // Lock entry and loss both restart pairing on a fresh A word
      if (lock_evt_s || (locked && viol_s)) begin
        a_pend_r <= 1'b0;
      end else if (v1_r && sel1_r) begin
        a_pend_r <= 1'b1;
      end else if (pair_s) begin
        a_pend_r <= 1'b0;
      end
      ovr0 <= set0_s | (ovr0 & ~ovr_clr);
      ovr1 <= set1_s | (ovr1 & ~ovr_clr);
    end
  end

endmodule

// File: tb/tb_fast_adc_capture.sv
// Directed bench for fast_adc_capture: default, offset-binary and 4-bit
// error-counter instances share one stimulus stream.
module tb_fast_adc_capture;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic [15:0] adc_d;
  logic        adc_sel;
  logic        ovr_clr;

  logic [15:0] s0, s1, ob_s0, ob_s1, e4_s0, e4_s1;
  logic        sv, lk, ov0, ov1;
  logic        ob_sv, ob_lk, ob_ov0, ob_ov1;
  logic        e4_sv, e4_lk, e4_ov0, e4_ov1;
  logic [7:0]  ec, ob_ec;
  logic [3:0]  e4_ec;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] a_raw;
    logic [15:0] b_raw;
    logic [15:0] ob_s0;
    logic [15:0] ob_s1;
    logic        ob_ovr0;
    logic        ob_ovr1;
  } fmt_vec_t;

  fmt_vec_t fv[6];

  always #5 clk_in = ~clk_in;

  fast_adc_capture dut (
    .clk_in(clk_in), .rst_n(rst_n), .adc_d(adc_d), .adc_sel(adc_sel), .ovr_clr(ovr_clr),
    .s_out0(s0), .s_out1(s1), .s_valid(sv), .locked(lk), .err_cnt(ec), .ovr0(ov0), .ovr1(ov1)
  );

  fast_adc_capture #(.OFFSET_BIN(1'b1)) dut_ob (
    .clk_in(clk_in), .rst_n(rst_n), .adc_d(adc_d), .adc_sel(adc_sel), .ovr_clr(ovr_clr),
    .s_out0(ob_s0), .s_out1(ob_s1), .s_valid(ob_sv), .locked(ob_lk), .err_cnt(ob_ec),
    .ovr0(ob_ov0), .ovr1(ob_ov1)
  );

  fast_adc_capture #(.ERR_W(4)) dut_e4 (
    .clk_in(clk_in), .rst_n(rst_n), .adc_d(adc_d), .adc_sel(adc_sel), .ovr_clr(ovr_clr),
    .s_out0(e4_s0), .s_out1(e4_s1), .s_valid(e4_sv), .locked(e4_lk), .err_cnt(e4_ec),
    .ovr0(e4_ov0), .ovr1(e4_ov1)
  );

  function automatic logic fs(input logic [15:0] w);
    return (w == 16'h7FFF) || (w == 16'h8000);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs checked there reflect the word
  // driven two slots earlier.
  task automatic word(input logic [15:0] d, input logic s, input logic c);
    @(negedge clk_in);
    adc_d   = d;
    adc_sel = s;
    ovr_clr = c;
  endtask

  // Alternating A/B stream starting on an A word right out of reset.
  task automatic run_lock(input string tag, input logic [15:0] base_a, input logic [15:0] base_b);
    for (int j = 0; j < 26; j++) begin
      if (j % 2 == 0) word(base_a + 16'(j / 2), 1'b1, 1'b0);
      else            word(base_b + 16'(j / 2), 1'b0, 1'b0);
      if (j == 0) rst_n = 1'b1;
      chk($sformatf("%s_locked_%0d", tag, j), 32'(lk), 32'(j >= 18));
      chk($sformatf("%s_valid_%0d", tag, j), 32'(sv), 32'((j >= 21) && (j % 2 == 1)));
      chk($sformatf("%s_err_%0d", tag, j), 32'(ec), 32'(0));
      chk($sformatf("%s_ovr_%0d", tag, j), 32'({ov0, ov1}), 32'(0));
      if ((j >= 21) && (j % 2 == 1)) begin
        chk($sformatf("%s_s0_%0d", tag, j), 32'(s0), 32'(base_a + 16'((j - 3) / 2)));
        chk($sformatf("%s_s1_%0d", tag, j), 32'(s1), 32'(base_b + 16'((j - 2) / 2)));
        chk($sformatf("%s_diff_%0d", tag, j), 32'(s1 - s0), 32'(base_b - base_a));
      end else if (j < 21) begin
        chk($sformatf("%s_s0_idle_%0d", tag, j), 32'(s0), 32'(0));
        chk($sformatf("%s_s1_idle_%0d", tag, j), 32'(s1), 32'(0));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fmt_vec_t p;
    rst_n   = 1'b0;
    adc_d   = 16'h0000;
    adc_sel = 1'b0;
    ovr_clr = 1'b0;
    fv[0] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 1'b1, 1'b1};
    fv[1] = '{16'h8000, 16'h8000, 16'h0000, 16'h0000, 1'b0, 1'b0};
    fv[2] = '{16'h1234, 16'h7FFF, 16'h9234, 16'hFFFF, 1'b0, 1'b0};
    fv[3] = '{16'hFFFE, 16'h0001, 16'h7FFE, 16'h8001, 1'b0, 1'b0};
    fv[4] = '{16'hFFFF, 16'h7FFE, 16'h7FFF, 16'hFFFE, 1'b1, 1'b0};
    fv[5] = '{16'h0100, 16'h0200, 16'h8100, 16'h8200, 1'b0, 1'b0};

    repeat (3) @(negedge clk_in);
    chk("rst_outputs", {s0, s1}, 32'(0));
    chk("rst_flags", 32'({sv, lk, ov0, ov1}), 32'(0));
    chk("rst_err", 32'(ec), 32'(0));
    chk("rst_err_e4", 32'(e4_ec), 32'(0));

    run_lock("lock", 16'h1000, 16'h2000);
    chk("ob_locked", 32'(ob_lk), 32'(1));

    // Format table: ovr_clr rides with each B word so flags show only that pair
    for (int i = 0; i < 6; i++) begin
      word(fv[i].a_raw, 1'b1, 1'b0);
      word(fv[i].b_raw, 1'b0, 1'b1);
      if (i > 0) begin
        p = fv[i-1];
        chk($sformatf("fmt_ob_valid_%0d", i-1), 32'(ob_sv), 32'(1));
        chk($sformatf("fmt_ob_s0_%0d", i-1), 32'(ob_s0), 32'(p.ob_s0));
        chk($sformatf("fmt_ob_s1_%0d", i-1), 32'(ob_s1), 32'(p.ob_s1));
        chk($sformatf("fmt_ob_ovr0_%0d", i-1), 32'(ob_ov0), 32'(p.ob_ovr0));
        chk($sformatf("fmt_ob_ovr1_%0d", i-1), 32'(ob_ov1), 32'(p.ob_ovr1));
        chk($sformatf("fmt_s0_%0d", i-1), 32'(s0), 32'(p.a_raw));
        chk($sformatf("fmt_s1_%0d", i-1), 32'(s1), 32'(p.b_raw));
        chk($sformatf("fmt_ovr0_%0d", i-1), 32'(ov0), 32'(fs(p.a_raw)));
        chk($sformatf("fmt_ovr1_%0d", i-1), 32'(ov1), 32'(fs(p.b_raw)));
      end
    end

    // Sticky overrange: set, clear alone, then clear coincident with a new set
    word(16'h7FFF, 1'b1, 1'b0);
    word(16'h2000, 1'b0, 1'b0);
    word(16'h1000, 1'b1, 1'b0);
    chk("sticky_set", 32'(ov0), 32'(1));
    chk("sticky_ob_none", 32'(ob_ov0), 32'(0));
    word(16'h2001, 1'b0, 1'b1);
    word(16'h1002, 1'b1, 1'b0);
    chk("sticky_clr", 32'(ov0), 32'(0));
    word(16'h2002, 1'b0, 1'b0);
    word(16'h7FFF, 1'b1, 1'b0);
    word(16'h2003, 1'b0, 1'b1);
    word(16'h1003, 1'b1, 1'b0);
    chk("set_wins", 32'(ov0), 32'(1));
    chk("set_wins_ovr1", 32'(ov1), 32'(0));

    // Slip: second consecutive A word at t=9, then 16 alternations to relock
    for (int t = 9; t < 32; t++) begin
      if (t % 2 == 1) word(16'h3000 + 16'(t), 1'b1, 1'b0);
      else            word(16'h4000 + 16'(t), 1'b0, 1'b0);
      chk($sformatf("slip_locked_%0d", t), 32'(lk), 32'((t <= 10) || (t >= 27)));
      chk($sformatf("slip_valid_%0d", t), 32'(sv), 32'((t == 9) || ((t >= 30) && (t % 2 == 0))));
      chk($sformatf("slip_err_%0d", t), 32'(ec), 32'((t >= 11) ? 1 : 0));
      if ((t >= 30) && (t % 2 == 0)) begin
        chk($sformatf("slip_s0_%0d", t), 32'(s0), 32'(16'h3000 + 16'(t - 3)));
        chk($sformatf("slip_s1_%0d", t), 32'(s1), 32'(16'h4000 + 16'(t - 2)));
      end
    end

    // Reset for one edge while an A word sits in the capture register
    word(16'h6000, 1'b0, 1'b0);
    chk("pre_rst_locked", 32'(lk), 32'(1));
    chk("pre_rst_err", 32'(ec), 32'(1));
    rst_n = 1'b0;
    run_lock("relock", 16'h5000, 16'h6000);

    // Constant A marker: every word after the first is a violation
    for (int k = 0; k < 42; k++) begin
      word(16'h7000 + 16'(k), 1'b1, 1'b0);
      if (k == 16) chk("sat_e4_14", 32'(e4_ec), 32'(14));
      if (k == 17) chk("sat_e4_15", 32'(e4_ec), 32'(15));
    end
    chk("sat_e4_hold", 32'(e4_ec), 32'(15));
    chk("sat_err8", 32'(ec), 32'(39));
    chk("sat_e4_locked", 32'(e4_lk), 32'(0));
    chk("sat_locked", 32'(lk), 32'(0));
    chk("sat_valid", 32'(sv), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
